// File: rtl/btb_pkg.sv
// Shared types and defaults for the BTB update path.
// The scheduler's optional same-cycle bypass is enabled by defining BTB_UPD_BYPASS_EN.
package btb_pkg;

    localparam int BTB_IDX_W     = 3;
    localparam int BTB_UPD_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } btb_upd_t;

    localparam int BTB_UPD_W = $bits(btb_upd_t);

endpackage

// File: rtl/btb_upd_fifo.sv
// Update queue storage: circular buffer with wrapping pointers and an occupancy count.
// Full/empty come from the count, so the pointers are free to wrap modulo DEPTH.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = BTB_UPD_DEPTH,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [BTB_UPD_W-1:0] i_data,
    output logic [BTB_UPD_W-1:0] o_head,
    output logic [PTR_W:0]       o_count
);

    logic [BTB_UPD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;

    // Storage itself needs no reset: nothing is read unless the count says it is valid.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/btb_update_scheduler.sv
// Buffers EX-stage branch resolutions and drains them in order into the BTB write port,
// holding them while memory_stall is high. Optional BTB_UPD_BYPASS_EN forwards into an empty queue.
module btb_update_scheduler
    import btb_pkg::*;
#(
    parameter int DEPTH = BTB_UPD_DEPTH,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memory_stall,
    input  logic             clear,
    input  logic             res_valid,
    input  logic             res_is_branch,
    input  logic [31:0]      res_pc,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    output logic             res_ready,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic [31:0]      upd_target,
    output logic [PTR_W:0]   occupancy
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic                 w_enq;
    logic                 w_q_valid;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_pop;
    btb_upd_t             w_res_entry;
    btb_upd_t             w_head;
    logic [BTB_UPD_W-1:0] w_head_bits;

    assign res_ready   = (occupancy != FULL_COUNT);
    assign w_enq       = res_valid & res_is_branch & res_ready & ~clear;
    assign w_q_valid   = (occupancy != '0) & ~memory_stall;
    assign w_res_entry = '{pc: res_pc, taken: res_taken, target: res_target};
    assign w_head      = btb_upd_t'(w_head_bits);

`ifdef BTB_UPD_BYPASS_EN
    assign w_bypass = (occupancy == '0) & ~memory_stall & upd_ready & w_enq;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed resolution is consumed by the BTB directly and never written to the queue.
    assign w_push = w_enq & ~w_bypass;
    assign w_pop  = w_q_valid & upd_ready & ~clear;

    // Update fields are forced to zero whenever nothing is being presented.
    always_comb begin
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        if (w_bypass) begin
            upd_valid  = 1'b1;
            upd_pc     = res_pc;
            upd_taken  = res_taken;
            upd_target = res_target;
        end else if (w_q_valid) begin
            upd_valid  = 1'b1;
            upd_pc     = w_head.pc;
            upd_taken  = w_head.taken;
            upd_target = w_head.target;
        end
    end

    btb_upd_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_res_entry),
        .o_head  (w_head_bits),
        .o_count (occupancy)
    );

endmodule
